// File: rtl/branch_target_buffer_pkg.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_pkg
// Shared definitions for the direct-mapped branch target buffer:
//   - two-bit prediction counter encodings (strong/weak, taken/not-taken)
//   - the kind of write the BTB performs in a given cycle
//   - helpers that slice a 64-bit PC into index and tag fields
// No ports; imported by the interface, the counter sub-module and the top.
// -----------------------------------------------------------------------------
package branch_target_buffer_pkg;

  // Counter encodings: the MSB alone is the taken/not-taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // What the table does at the next clock edge. Flush outranks any update.
  typedef enum logic [2:0] {
    UPD_NONE,
    UPD_FLUSH,
    UPD_HIT_JUMP,
    UPD_HIT_COND,
    UPD_ALLOC
  } upd_kind_e;

  // Entry index: the word-address bits just above the byte offset.
  // Returned at full width so callers cast down to their own index width.
  function automatic logic [63:0] pcIndex(input logic [63:0] pc, input int idxW);
    return (pc >> 2) & ((64'd1 << idxW) - 64'd1);
  endfunction

  // Tag: the tagW bits directly above the index field.
  function automatic logic [63:0] pcTag(input logic [63:0] pc, input int idxW,
                                        input int tagW);
    return (pc >> (idxW + 2)) & ((64'd1 << tagW) - 64'd1);
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_if
// Bundles the fetch-side lookup, execute-side resolution and statistics
// signals of the branch target buffer.
//   master : pipeline side (drives PCF/LookupF, execute resolution, FlushBTB)
//   slave  : BTB side (drives predictions, MispredictE and the counters)
// Parameter CNT_W sets the width of LookupCount / MispredCount.
// -----------------------------------------------------------------------------
interface branch_target_buffer_if #(
  parameter int CNT_W = 32
);

  // Maintenance
  logic             FlushBTB;

  // Fetch-stage lookup
  logic [63:0]      PCF;
  logic             LookupF;
  logic             PredTakenF;
  logic [63:0]      PredTargetF;

  // Execute-stage resolution
  logic             UpdateE;
  logic [63:0]      PCE;
  logic [63:0]      PCTargetE;
  logic             TakenE;
  logic             JumpE;
  logic             PredTakenE;
  logic [63:0]      PredTargetE;
  logic             MispredictE;

  // Statistics
  logic [CNT_W-1:0] LookupCount;
  logic [CNT_W-1:0] MispredCount;

  modport master (
    output FlushBTB, PCF, LookupF,
    output UpdateE, PCE, PCTargetE, TakenE, JumpE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, LookupCount, MispredCount
  );

  modport slave (
    input  FlushBTB, PCF, LookupF,
    input  UpdateE, PCE, PCTargetE, TakenE, JumpE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, LookupCount, MispredCount
  );

endinterface

// File: rtl/branch_target_buffer_sat_ctr.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_sat_ctr
// Next-state function of a two-bit saturating up/down prediction counter.
//   ctr_i  in  2  current counter value
//   up_i   in  1  1 = branch resolved taken (count up), 0 = count down
//   ctr_o  out 2  updated value, clamped to 00..11
// Purely combinational; the owning table holds the state.
// -----------------------------------------------------------------------------
module branch_target_buffer_sat_ctr
  import branch_target_buffer_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       up_i,
  output logic [1:0] ctr_o
);

  // Step one state toward the resolved direction, but never wrap past
  // strongly-taken or strongly-not-taken.
  always_comb begin
    ctr_o = ctr_i;
    if (up_i) begin
      if (ctr_i != CTR_ST) begin
        ctr_o = ctr_i + 2'b01;
      end
    end else begin
      if (ctr_i != CTR_SNT) begin
        ctr_o = ctr_i - 2'b01;
      end
    end
  end

endmodule

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped branch target buffer for the fetch stage. Every cycle PCF is
// looked up against stored state to produce a predicted redirect; the execute
// stage reports resolved branches/jumps, which train the table. Also flags
// mispredicts and keeps saturating lookup/mispredict statistics.
//   clk  in  1  clock, all state changes on the rising edge
//   rst  in  1  synchronous active-high reset
//   btb  slave modport of branch_target_buffer_if:
//        FlushBTB, PCF, LookupF, UpdateE, PCE, PCTargetE, TakenE, JumpE,
//        PredTakenE, PredTargetE in; PredTakenF, PredTargetF, MispredictE,
//        LookupCount, MispredCount out
// Parameters: ENTRIES (power of two, >=2), TAG_W, CNT_W (must match the
// interface instance).
// -----------------------------------------------------------------------------
module branch_target_buffer
  import branch_target_buffer_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 20,
  parameter int CNT_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_target_buffer_if.slave  btb
);

  localparam int IDX_W = $clog2(ENTRIES);

  typedef struct packed {
    logic             valid;
    logic             isJump;
    logic [TAG_W-1:0] tag;
    logic [63:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t       entries_q [ENTRIES];
  btb_entry_t       entries_d [ENTRIES];

  logic [IDX_W-1:0] fetchIdx;
  logic [TAG_W-1:0] fetchTag;
  btb_entry_t       fetchEntry;
  logic             fetchHit;
  logic             predTakenF;

  logic [IDX_W-1:0] execIdx;
  logic [TAG_W-1:0] execTag;
  btb_entry_t       execEntry;
  logic             execHit;
  logic [1:0]       condCtr;
  upd_kind_e        updKind;

  logic [CNT_W-1:0] lookupCount_q;
  logic [CNT_W-1:0] mispredCount_q;
  logic             mispredictE;

  // Split both PCs into index/tag. The low two PC bits never participate.
  assign fetchIdx = IDX_W'(pcIndex(btb.PCF, IDX_W));
  assign fetchTag = TAG_W'(pcTag(btb.PCF, IDX_W, TAG_W));
  assign execIdx  = IDX_W'(pcIndex(btb.PCE, IDX_W));
  assign execTag  = TAG_W'(pcTag(btb.PCE, IDX_W, TAG_W));

  // Fetch lookup reads registered state only, so a same-cycle write to the
  // same entry is seen by the following cycle, not this one.
  assign fetchEntry = entries_q[fetchIdx];
  assign fetchHit   = fetchEntry.valid && (fetchEntry.tag == fetchTag);
  assign predTakenF = fetchHit && (fetchEntry.isJump || fetchEntry.ctr[1]);

  assign btb.PredTakenF  = predTakenF;
  assign btb.PredTargetF = predTakenF ? fetchEntry.target : 64'h0;

  // Execute side: does the resolved instruction already own its entry?
  assign execEntry = entries_q[execIdx];
  assign execHit   = execEntry.valid && (execEntry.tag == execTag);

  branch_target_buffer_sat_ctr uSatCtr (
    .ctr_i (execEntry.ctr),
    .up_i  (btb.TakenE),
    .ctr_o (condCtr)
  );

  // Classify this cycle's table write. A flush cancels any update so that
  // nothing is allocated into a table that is being wiped. Not-taken misses
  // leave the table alone: there is no target worth remembering.
  always_comb begin
    updKind = UPD_NONE;
    if (btb.FlushBTB) begin
      updKind = UPD_FLUSH;
    end else if (btb.UpdateE) begin
      if (execHit) begin
        updKind = btb.JumpE ? UPD_HIT_JUMP : UPD_HIT_COND;
      end else if (btb.TakenE) begin
        updKind = UPD_ALLOC;
      end
    end
  end

  // Next-state table contents. Only the entry selected by PCE changes,
  // except on a flush which drops every valid bit but keeps the payload.
  // A conditional hit keeps the old target when not taken, since the taken
  // target is the only one the predictor ever redirects to.
  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      entries_d[i] = entries_q[i];
    end
    case (updKind)
      UPD_FLUSH: begin
        for (int i = 0; i < ENTRIES; i++) begin
          entries_d[i].valid = 1'b0;
        end
      end
      UPD_HIT_JUMP: begin
        entries_d[execIdx].target = btb.PCTargetE;
        entries_d[execIdx].ctr    = CTR_ST;
        entries_d[execIdx].isJump = 1'b1;
      end
      UPD_HIT_COND: begin
        entries_d[execIdx].ctr = condCtr;
        if (btb.TakenE) begin
          entries_d[execIdx].target = btb.PCTargetE;
        end
      end
      UPD_ALLOC: begin
        entries_d[execIdx] = '{
          valid:  1'b1,
          isJump: btb.JumpE,
          tag:    execTag,
          target: btb.PCTargetE,
          ctr:    (btb.JumpE ? CTR_ST : CTR_WT)
        };
      end
      default: begin
      end
    endcase
  end

  // Table registers. Reset takes priority over any pending write so the
  // first post-reset cycle always predicts not-taken with a zero target.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= entries_d[i];
      end
    end
  end

  // A resolved instruction needs a redirect if the direction was wrong, or
  // if it was correctly predicted taken but toward the wrong address.
  assign mispredictE = btb.UpdateE &&
                       ((btb.TakenE != btb.PredTakenE) ||
                        (btb.TakenE && btb.PredTakenE &&
                         (btb.PredTargetE != btb.PCTargetE)));

  assign btb.MispredictE = mispredictE;

  // Statistics counters stick at all-ones instead of wrapping, and they
  // survive a table flush; only reset clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      lookupCount_q  <= '0;
      mispredCount_q <= '0;
    end else begin
      if (btb.LookupF && (lookupCount_q != '1)) begin
        lookupCount_q <= lookupCount_q + CNT_W'(1);
      end
      if (mispredictE && (mispredCount_q != '1)) begin
        mispredCount_q <= mispredCount_q + CNT_W'(1);
      end
    end
  end

  assign btb.LookupCount  = lookupCount_q;
  assign btb.MispredCount = mispredCount_q;

endmodule

// File: tb/tb_branch_target_buffer.sv
// -----------------------------------------------------------------------------
// tb_branch_target_buffer
// Self-checking bench for branch_target_buffer. A 16-entry instance is driven
// through reset, allocation, counter hysteresis, jumps, flush/bypass corners
// and mispredict detection; a second instance with 4-bit counters is used to
// see the lookup counter stick at all-ones.
// -----------------------------------------------------------------------------
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;

  typedef struct {
    logic [63:0] pc;
    logic        lookup;
    logic        flush;
    logic        upd;
    logic [63:0] pce;
    logic [63:0] tgt;
    logic        taken;
    logic        jump;
    logic        predTaken;
    logic [63:0] predTarget;
    logic        expMis;
    logic        expTaken;
    logic [63:0] expTarget;
  } step_t;

  typedef struct {
    logic        taken;
    logic [63:0] target;
  } pred_t;

  logic        clk;
  logic        rst;
  int          compared;
  int          mismatched;
  logic [31:0] lookupsExp;
  logic [31:0] mispredExp;
  logic [31:0] lookBefore;
  logic [31:0] misBefore;
  pred_t       sbQ[$];

  branch_target_buffer_if #(.CNT_W(32)) bif ();
  branch_target_buffer_if #(.CNT_W(4))  sif ();

  branch_target_buffer #(.ENTRIES(ENTRIES), .TAG_W(20), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .btb (bif)
  );

  branch_target_buffer #(.ENTRIES(ENTRIES), .TAG_W(20), .CNT_W(4)) dutSat (
    .clk (clk),
    .rst (rst),
    .btb (sif)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic step_t mk(input logic [63:0] pc, input logic lookup,
                               input logic expTaken, input logic [63:0] expTarget);
    step_t s;
    s = '{pc: pc, lookup: lookup, flush: 1'b0, upd: 1'b0, pce: 64'h0,
          tgt: 64'h0, taken: 1'b0, jump: 1'b0, predTaken: 1'b0,
          predTarget: 64'h0, expMis: 1'b0, expTaken: expTaken,
          expTarget: expTarget};
    return s;
  endfunction

  function automatic step_t withUpd(input step_t sIn, input logic [63:0] pce,
                                    input logic [63:0] tgt, input logic taken,
                                    input logic jump);
    step_t s;
    s       = sIn;
    s.upd   = 1'b1;
    s.pce   = pce;
    s.tgt   = tgt;
    s.taken = taken;
    s.jump  = jump;
    return s;
  endfunction

  // Drive one cycle's inputs on the falling edge, queue the prediction the
  // bench expects for it, and advance the counter model. The counters seen
  // during this cycle reflect only earlier cycles, hence the *Before copies.
  task automatic applyStimulus(input step_t s);
    pred_t p;
    @(negedge clk);
    bif.FlushBTB    = s.flush;
    bif.PCF         = s.pc;
    bif.LookupF     = s.lookup;
    bif.UpdateE     = s.upd;
    bif.PCE         = s.pce;
    bif.PCTargetE   = s.tgt;
    bif.TakenE      = s.taken;
    bif.JumpE       = s.jump;
    bif.PredTakenE  = s.predTaken;
    bif.PredTargetE = s.predTarget;
    p.taken  = s.expTaken;
    p.target = s.expTarget;
    sbQ.push_back(p);
    lookBefore = lookupsExp;
    misBefore  = mispredExp;
    if (s.lookup) lookupsExp++;
    if (s.upd && ((s.taken != s.predTaken) ||
                  (s.taken && s.predTaken && (s.predTarget != s.tgt))))
      mispredExp++;
  endtask

  task automatic test_reset();
    step_t tab[$];
    pred_t exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tab.push_back(mk(64'h1000, 1'b0, 1'b0, 64'h0));
    foreach (tab[i]) begin
      applyStimulus(tab[i]);
      #1;
      exp = sbQ.pop_front();
      compared++;
      if (bif.PredTakenF !== exp.taken || bif.PredTargetF !== exp.target) begin
        mismatched++;
        $display("[TB] FAIL reset_pred: got %0b/%h want %0b/%h",
                 bif.PredTakenF, bif.PredTargetF, exp.taken, exp.target);
      end
      compared++;
      if (bif.LookupCount !== 32'h0 || bif.MispredCount !== 32'h0 ||
          sif.LookupCount !== 4'h0 || bif.MispredictE !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_counts: got L=%0d M=%0d S=%0d mis=%0b want 0/0/0/0",
                 bif.LookupCount, bif.MispredCount, sif.LookupCount, bif.MispredictE);
      end
    end
  endtask

  task automatic test_alloc();
    step_t tab[$];
    pred_t exp;
    tab.push_back(withUpd(mk(64'h1000, 1'b1, 1'b0, 64'h0), 64'h1000, 64'h1040, 1'b1, 1'b0));
    tab.push_back(mk(64'h1000, 1'b1, 1'b1, 64'h1040));
    tab.push_back(mk(64'h1000 + ENTRIES * 4, 1'b1, 1'b0, 64'h0));
    foreach (tab[i]) begin
      applyStimulus(tab[i]);
      #1;
      exp = sbQ.pop_front();
      compared++;
      if (bif.PredTakenF !== exp.taken || bif.PredTargetF !== exp.target) begin
        mismatched++;
        $display("[TB] FAIL alloc_pred[%0d]: got %0b/%h want %0b/%h", i,
                 bif.PredTakenF, bif.PredTargetF, exp.taken, exp.target);
      end
      compared++;
      if (bif.LookupCount !== lookBefore || bif.MispredCount !== misBefore) begin
        mismatched++;
        $display("[TB] FAIL alloc_counts[%0d]: got %0d/%0d want %0d/%0d", i,
                 bif.LookupCount, bif.MispredCount, lookBefore, misBefore);
      end
    end
  endtask

  task automatic test_hysteresis();
    step_t tab[$];
    pred_t exp;
    tab.push_back(withUpd(mk(64'h1000, 1'b1, 1'b1, 64'h1040), 64'h1000, 64'h1040, 1'b0, 1'b0));
    tab.push_back(withUpd(mk(64'h1000, 1'b1, 1'b0, 64'h0), 64'h1000, 64'h1040, 1'b0, 1'b0));
    tab.push_back(withUpd(mk(64'h1000, 1'b1, 1'b0, 64'h0), 64'h1000, 64'h1040, 1'b1, 1'b0));
    tab.push_back(withUpd(mk(64'h1000, 1'b1, 1'b0, 64'h0), 64'h1000, 64'h1040, 1'b1, 1'b0));
    tab.push_back(mk(64'h1000, 1'b1, 1'b1, 64'h1040));
    foreach (tab[i]) begin
      applyStimulus(tab[i]);
      #1;
      exp = sbQ.pop_front();
      compared++;
      if (bif.PredTakenF !== exp.taken || bif.PredTargetF !== exp.target) begin
        mismatched++;
        $display("[TB] FAIL hyst_pred[%0d]: got %0b/%h want %0b/%h", i,
                 bif.PredTakenF, bif.PredTargetF, exp.taken, exp.target);
      end
      compared++;
      if (bif.LookupCount !== lookBefore || bif.MispredCount !== misBefore) begin
        mismatched++;
        $display("[TB] FAIL hyst_counts[%0d]: got %0d/%0d want %0d/%0d", i,
                 bif.LookupCount, bif.MispredCount, lookBefore, misBefore);
      end
    end
  endtask

  task automatic test_jump();
    step_t tab[$];
    pred_t exp;
    tab.push_back(withUpd(mk(64'h2000, 1'b1, 1'b0, 64'h0), 64'h2000,
                          64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1'b1));
    tab.push_back(withUpd(mk(64'h2000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0), 64'h2000,
                          64'h2004, 1'b0, 1'b0));
    tab.push_back(withUpd(mk(64'h2000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0), 64'h2000,
                          64'h2004, 1'b0, 1'b0));
    tab.push_back(mk(64'h2000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0));
    tab.push_back(mk(64'h1000, 1'b1, 1'b0, 64'h0));
    foreach (tab[i]) begin
      applyStimulus(tab[i]);
      #1;
      exp = sbQ.pop_front();
      compared++;
      if (bif.PredTakenF !== exp.taken || bif.PredTargetF !== exp.target) begin
        mismatched++;
        $display("[TB] FAIL jump_pred[%0d]: got %0b/%h want %0b/%h", i,
                 bif.PredTakenF, bif.PredTargetF, exp.taken, exp.target);
      end
      compared++;
      if (bif.LookupCount !== lookBefore || bif.MispredCount !== misBefore) begin
        mismatched++;
        $display("[TB] FAIL jump_counts[%0d]: got %0d/%0d want %0d/%0d", i,
                 bif.LookupCount, bif.MispredCount, lookBefore, misBefore);
      end
    end
  endtask

  task automatic test_corner();
    step_t tab[$];
    step_t s;
    pred_t exp;
    s = withUpd(mk(64'h2000, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF0), 64'h3000,
                64'h3333, 1'b1, 1'b0);
    s.flush = 1'b1;
    tab.push_back(s);
    tab.push_back(mk(64'h2000, 1'b1, 1'b0, 64'h0));
    tab.push_back(mk(64'h3000, 1'b1, 1'b0, 64'h0));
    tab.push_back(withUpd(mk(64'h4000, 1'b1, 1'b0, 64'h0), 64'h4000, 64'h4100, 1'b1, 1'b0));
    tab.push_back(withUpd(mk(64'h4000, 1'b1, 1'b1, 64'h4100), 64'h4040, 64'h5000, 1'b1, 1'b1));
    tab.push_back(mk(64'h4000, 1'b1, 1'b0, 64'h0));
    tab.push_back(mk(64'h4040, 1'b0, 1'b1, 64'h5000));
    foreach (tab[i]) begin
      applyStimulus(tab[i]);
      #1;
      exp = sbQ.pop_front();
      compared++;
      if (bif.PredTakenF !== exp.taken || bif.PredTargetF !== exp.target) begin
        mismatched++;
        $display("[TB] FAIL corner_pred[%0d]: got %0b/%h want %0b/%h", i,
                 bif.PredTakenF, bif.PredTargetF, exp.taken, exp.target);
      end
      compared++;
      if (bif.LookupCount !== lookBefore || bif.MispredCount !== misBefore) begin
        mismatched++;
        $display("[TB] FAIL corner_counts[%0d]: got %0d/%0d want %0d/%0d", i,
                 bif.LookupCount, bif.MispredCount, lookBefore, misBefore);
      end
    end
  endtask

  task automatic test_mispredict();
    step_t tab[$];
    step_t s;
    pred_t exp;
    // Right direction, wrong target.
    s = withUpd(mk(64'h0, 1'b0, 1'b0, 64'h0), 64'h1000, 64'h1080, 1'b1, 1'b0);
    s.predTaken = 1'b1; s.predTarget = 64'h1040; s.expMis = 1'b1;
    tab.push_back(s);
    // Correctly predicted not-taken.
    s = withUpd(mk(64'h0, 1'b0, 1'b0, 64'h0), 64'h1000, 64'h1080, 1'b0, 1'b0);
    s.expMis = 1'b0;
    tab.push_back(s);
    // Correct direction and target.
    s = withUpd(mk(64'h0, 1'b0, 1'b0, 64'h0), 64'h1000, 64'h1080, 1'b1, 1'b0);
    s.predTaken = 1'b1; s.predTarget = 64'h1080; s.expMis = 1'b0;
    tab.push_back(s);
    // Predicted not-taken but taken.
    s = withUpd(mk(64'h0, 1'b0, 1'b0, 64'h0), 64'h1000, 64'h1080, 1'b1, 1'b0);
    s.expMis = 1'b1;
    tab.push_back(s);
    // No resolution this cycle: disagreeing inputs must be ignored.
    s = mk(64'h0, 1'b0, 1'b0, 64'h0);
    s.predTaken = 1'b1; s.predTarget = 64'h1234; s.expMis = 1'b0;
    tab.push_back(s);
    tab.push_back(mk(64'h0, 1'b0, 1'b0, 64'h0));
    foreach (tab[i]) begin
      applyStimulus(tab[i]);
      #1;
      exp = sbQ.pop_front();
      compared++;
      if (bif.MispredictE !== tab[i].expMis) begin
        mismatched++;
        $display("[TB] FAIL mispredict[%0d]: got %0b want %0b", i,
                 bif.MispredictE, tab[i].expMis);
      end
      compared++;
      if (bif.PredTakenF !== exp.taken || bif.PredTargetF !== exp.target) begin
        mismatched++;
        $display("[TB] FAIL mis_pred[%0d]: got %0b/%h want %0b/%h", i,
                 bif.PredTakenF, bif.PredTargetF, exp.taken, exp.target);
      end
      compared++;
      if (bif.LookupCount !== lookBefore || bif.MispredCount !== misBefore) begin
        mismatched++;
        $display("[TB] FAIL mis_counts[%0d]: got %0d/%0d want %0d/%0d", i,
                 bif.LookupCount, bif.MispredCount, lookBefore, misBefore);
      end
    end
  endtask

  // The 4-bit instance counts 14 lookups, reaches 4'hF on the 15th and must
  // stay there however many more follow.
  task automatic test_saturation();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      sif.LookupF = 1'b1;
    end
    @(negedge clk);
    #1;
    compared++;
    if (sif.LookupCount !== 4'hE) begin
      mismatched++;
      $display("[TB] FAIL sat_14: got %h want e", sif.LookupCount);
    end
    @(negedge clk);
    #1;
    compared++;
    if (sif.LookupCount !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL sat_15: got %h want f", sif.LookupCount);
    end
    repeat (6) @(negedge clk);
    #1;
    compared++;
    if (sif.LookupCount !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL sat_hold: got %h want f", sif.LookupCount);
    end
    sif.LookupF = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    lookupsExp = 32'h0;
    mispredExp = 32'h0;
    lookBefore = 32'h0;
    misBefore  = 32'h0;
    rst        = 1'b1;
    bif.FlushBTB = 1'b0; bif.PCF = 64'h0; bif.LookupF = 1'b0; bif.UpdateE = 1'b0;
    bif.PCE = 64'h0; bif.PCTargetE = 64'h0; bif.TakenE = 1'b0; bif.JumpE = 1'b0;
    bif.PredTakenE = 1'b0; bif.PredTargetE = 64'h0;
    sif.FlushBTB = 1'b0; sif.PCF = 64'h0; sif.LookupF = 1'b0; sif.UpdateE = 1'b0;
    sif.PCE = 64'h0; sif.PCTargetE = 64'h0; sif.TakenE = 1'b0; sif.JumpE = 1'b0;
    sif.PredTakenE = 1'b0; sif.PredTargetE = 64'h0;

    test_reset();
    test_alloc();
    test_hysteresis();
    test_jump();
    test_corner();
    test_mispredict();
    test_saturation();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
